// File: rtl/ecc_mul_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ecc_mul_arbiter_if
// Description : Bundle of the two requester handshakes plus the shared
//               GF(2^m) multiplier handshake seen by ecc_mul_arbiter.
//               slave  = the arbiter side, master = the environment side
//               (controller FSMs and multiplier core together).
// Revision    : 1.0 - initial release
// ============================================================================
interface ecc_mul_arbiter_if #(
   parameter int WIDTH = 163
);
   // requester port 0
   logic             REQ0;
   logic [WIDTH-1:0] A0;
   logic [WIDTH-1:0] B0;
   logic             GNT0;
   logic             DONE0;
   logic             ERR0;

   // requester port 1
   logic             REQ1;
   logic [WIDTH-1:0] A1;
   logic [WIDTH-1:0] B1;
   logic             GNT1;
   logic             DONE1;
   logic             ERR1;

   // shared result / status
   logic [WIDTH-1:0] RESULT;
   logic             BUSY;

   // multiplier core handshake
   logic [WIDTH-1:0] MUL_A;
   logic [WIDTH-1:0] MUL_B;
   logic             MUL_IN_VALID;
   logic [WIDTH-1:0] MUL_OUT;
   logic             MUL_OUT_VALID;
   logic             MUL_ERROR;

   modport slave (
      input  REQ0, A0, B0, REQ1, A1, B1,
      input  MUL_OUT, MUL_OUT_VALID, MUL_ERROR,
      output GNT0, DONE0, ERR0, GNT1, DONE1, ERR1,
      output RESULT, BUSY,
      output MUL_A, MUL_B, MUL_IN_VALID
   );

   modport master (
      output REQ0, A0, B0, REQ1, A1, B1,
      output MUL_OUT, MUL_OUT_VALID, MUL_ERROR,
      input  GNT0, DONE0, ERR0, GNT1, DONE1, ERR1,
      input  RESULT, BUSY,
      input  MUL_A, MUL_B, MUL_IN_VALID
   );
endinterface
`default_nettype wire

// File: rtl/ecc_mul_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ecc_mul_arbiter
// Description : Shares one GF(2^m) field multiplier between two sequencing
//               FSMs. Requests are granted one at a time in round-robin
//               order; the product (or an error) is routed back to the port
//               that owns the operation as a one-cycle DONE/ERR pulse.
//               Optional feature macro: ECC_MUL_ARB_TIMEOUT_EN - aborts a
//               multiplication with ERR when the core stays silent for
//               TIMEOUT cycles in WAIT. Without it WAIT never times out.
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_mul_arbiter #(
   parameter int WIDTH   = 163,
   parameter int TIMEOUT = 255
) (
   input  logic               CLK,
   input  logic               RST_N,
   ecc_mul_arbiter_if.slave   bus
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_issue = 2'd1;
   localparam logic [1:0] c_st_wait  = 2'd2;
   localparam logic [1:0] c_st_fin   = 2'd3;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [1:0]       r_state;
   logic             r_owner;        // port owning the in-flight operation
   logic             r_last;         // port granted most recently
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_mul_a;
   logic [WIDTH-1:0] r_mul_b;
   logic             r_mul_in_valid;
   logic [1:0]       r_gnt;          // index = port
   logic [1:0]       r_done;
   logic [1:0]       r_err;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic             w_any_req;
   logic             w_sel;          // port picked this IDLE cycle
   logic [WIDTH-1:0] w_sel_a;
   logic [WIDTH-1:0] w_sel_b;
   logic             w_timeout;      // WAIT has run out of patience

   // Round-robin pick: a lone request wins outright, a tie goes to the port
   // that was not served last.
   always_comb begin
      w_any_req = bus.REQ0 | bus.REQ1;
      w_sel     = 1'b0;
      if (bus.REQ0 && bus.REQ1) begin
         w_sel = ~r_last;
      end else if (bus.REQ1) begin
         w_sel = 1'b1;
      end
      w_sel_a = w_sel ? bus.A1 : bus.A0;
      w_sel_b = w_sel ? bus.B1 : bus.B0;
   end

`ifdef ECC_MUL_ARB_TIMEOUT_EN
   // ------------------------------------------------------------------------
   // WAIT watchdog. The counter is cleared in ISSUE so it starts at zero on
   // the first WAIT cycle and stops advancing once it hits TIMEOUT.
   // ------------------------------------------------------------------------
   localparam int c_cnt_w = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   logic [c_cnt_w-1:0] r_cnt;

   assign w_timeout = (r_cnt == c_cnt_w'(TIMEOUT));

   // Count silent WAIT cycles; a response of any kind ends the operation.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_cnt <= '0;
      end else if (r_state == c_st_issue) begin
         r_cnt <= '0;
      end else if ((r_state == c_st_wait) && !bus.MUL_OUT_VALID &&
                   !bus.MUL_ERROR && !w_timeout) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
`else
   // Without the watchdog WAIT only ends on a multiplier response.
   logic w_unused_timeout;

   assign w_timeout        = 1'b0;
   assign w_unused_timeout = (TIMEOUT > 0);
`endif

   // ------------------------------------------------------------------------
   // Main sequencer. Pulse outputs are registered and default low, so every
   // GNT/DONE/ERR/MUL_IN_VALID lasts exactly one cycle. Since only one
   // transition fires per cycle, at most one pulse is ever high.
   // ------------------------------------------------------------------------
   // Arbitration FSM with registered operand, result and pulse outputs.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state        <= c_st_idle;
         r_owner        <= 1'b0;
         r_last         <= 1'b1;     // port 0 wins the first tie
         r_result       <= '0;
         r_mul_a        <= '0;
         r_mul_b        <= '0;
         r_mul_in_valid <= 1'b0;
         r_gnt          <= 2'b00;
         r_done         <= 2'b00;
         r_err          <= 2'b00;
      end else begin
         r_mul_in_valid <= 1'b0;
         r_gnt          <= 2'b00;
         r_done         <= 2'b00;
         r_err          <= 2'b00;

         case (r_state)
            c_st_idle: begin
               // Requests are only looked at here; the grant pulse and the
               // multiplier start become visible in the ISSUE cycle.
               if (w_any_req) begin
                  r_owner        <= w_sel;
                  r_last         <= w_sel;
                  r_mul_a        <= w_sel_a;
                  r_mul_b        <= w_sel_b;
                  r_mul_in_valid <= 1'b1;
                  r_gnt[w_sel]   <= 1'b1;
                  r_state        <= c_st_issue;
               end
            end

            c_st_issue: begin
               r_state <= c_st_wait;
            end

            c_st_wait: begin
               // An error beats a simultaneous product; a product beats a
               // watchdog expiry in the same cycle.
               if (bus.MUL_ERROR) begin
                  r_err[r_owner] <= 1'b1;
                  r_state        <= c_st_idle;
               end else if (bus.MUL_OUT_VALID) begin
                  r_result        <= bus.MUL_OUT;
                  r_done[r_owner] <= 1'b1;
                  r_state         <= c_st_fin;
               end else if (w_timeout) begin
                  r_err[r_owner] <= 1'b1;
                  r_state        <= c_st_idle;
               end
            end

            c_st_fin: begin
               // DONE is high during this cycle; hand back to arbitration.
               r_state <= c_st_idle;
            end

            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.GNT0         = r_gnt[0];
   assign bus.GNT1         = r_gnt[1];
   assign bus.DONE0        = r_done[0];
   assign bus.DONE1        = r_done[1];
   assign bus.ERR0         = r_err[0];
   assign bus.ERR1         = r_err[1];
   assign bus.RESULT       = r_result;
   assign bus.BUSY         = (r_state != c_st_idle);
   assign bus.MUL_A        = r_mul_a;
   assign bus.MUL_B        = r_mul_b;
   assign bus.MUL_IN_VALID = r_mul_in_valid;

endmodule
`default_nettype wire

// File: tb/tb_ecc_mul_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ecc_mul_arbiter
// Description : Self-checking bench for ecc_mul_arbiter. A behavioural
//               multiplier answers each start pulse with the carry-less
//               product of the issued operands; expected grants and
//               completions are queued as stimulus is driven and popped as
//               the arbiter produces them.
//               Honours ECC_MUL_ARB_TIMEOUT_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ecc_mul_arbiter;

   localparam int W  = 163;
   localparam int TO = 8;

   typedef struct {
      logic         port;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } gnt_t;

   typedef struct {
      logic         port;
      logic         is_err;
      logic [W-1:0] val;
      logic         chk_lat;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   ecc_mul_arbiter_if #(.WIDTH(W)) bus ();

   ecc_mul_arbiter #(
      .WIDTH   (W),
      .TIMEOUT (TO)
   ) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   int           n_checks    = 0;
   int           n_fail      = 0;
   int           cyc         = 0;
   int           valid_cyc   = -1;
   int           mul_lat     = 4;
   int           mul_mode    = 0;   // 0 ok, 1 err+valid, 2 silent, 3 err only
   int           stray_req   = 0;
   logic [W-1:0] last_result = '0;
   gnt_t         gq[$];
   exp_t         sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] clmul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < W; i++) begin
         if (b[i]) r = r ^ (a << i);
      end
      return r;
   endfunction

   // Behavioural multiplier core plus stray-pulse injector.
   initial begin : mul_model
      logic [W-1:0] p;
      int           mode;
      int           stray_done;
      stray_done        = 0;
      bus.MUL_OUT       = '0;
      bus.MUL_OUT_VALID = 1'b0;
      bus.MUL_ERROR     = 1'b0;
      forever begin
         @(negedge clk);
         if (stray_req != stray_done) begin
            stray_done        = stray_req;
            bus.MUL_OUT       = '1;
            bus.MUL_OUT_VALID = 1'b1;
            bus.MUL_ERROR     = 1'b1;
            @(negedge clk);
            bus.MUL_OUT       = '0;
            bus.MUL_OUT_VALID = 1'b0;
            bus.MUL_ERROR     = 1'b0;
         end else if (bus.MUL_IN_VALID === 1'b1 && mul_mode != 2) begin
            mode = mul_mode;
            p    = clmul(bus.MUL_A, bus.MUL_B);
            repeat (mul_lat) @(negedge clk);
            bus.MUL_OUT       = p;
            bus.MUL_OUT_VALID = (mode != 3);
            bus.MUL_ERROR     = (mode == 1 || mode == 3);
            valid_cyc         = cyc + 1;
            @(negedge clk);
            bus.MUL_OUT       = '0;
            bus.MUL_OUT_VALID = 1'b0;
            bus.MUL_ERROR     = 1'b0;
         end
      end
   end

   // Scoreboard monitor: every grant and completion is matched in order.
   initial begin : monitor
      gnt_t g;
      exp_t e;
      int   np;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            last_result = '0;
         end else begin
            np = int'(bus.GNT0) + int'(bus.GNT1) + int'(bus.DONE0) +
                 int'(bus.DONE1) + int'(bus.ERR0) + int'(bus.ERR1);
            chk("pulse_onehot", (np <= 1), 1'b1);
            if (bus.GNT0 || bus.GNT1) begin
               if (gq.size() == 0) begin
                  chk("gnt_unexpected", {bus.GNT1, bus.GNT0}, 2'b00);
               end else begin
                  g = gq.pop_front();
                  chk("gnt_port", bus.GNT1, g.port);
                  chk("gnt_mul_in_valid", bus.MUL_IN_VALID, 1'b1);
                  chk("gnt_mul_a", bus.MUL_A, g.a);
                  chk("gnt_mul_b", bus.MUL_B, g.b);
               end
            end
            if (bus.DONE0 || bus.DONE1 || bus.ERR0 || bus.ERR1) begin
               if (sb.size() == 0) begin
                  chk("cpl_unexpected", {bus.ERR1, bus.ERR0, bus.DONE1, bus.DONE0}, 4'b0000);
               end else begin
                  e = sb.pop_front();
                  chk("cpl_port", bus.DONE1 | bus.ERR1, e.port);
                  chk("cpl_kind", bus.ERR0 | bus.ERR1, e.is_err);
                  if (!e.is_err) last_result = e.val;
                  chk("cpl_result", bus.RESULT, last_result);
                  if (e.chk_lat) chk("cpl_latency", cyc, valid_cyc);
               end
            end
         end
      end
   end

   // Hold RST_N low for n cycles and check every output is at its reset value.
   task automatic reset_for(input int n);
      rst_n = 1'b0;
      repeat (n) @(negedge clk);
      chk("rst_ctl", {bus.GNT0, bus.GNT1, bus.DONE0, bus.DONE1, bus.ERR0,
                      bus.ERR1, bus.BUSY, bus.MUL_IN_VALID}, 8'h00);
      chk("rst_result", bus.RESULT, '0);
      chk("rst_mul_a", bus.MUL_A, '0);
      chk("rst_mul_b", bus.MUL_B, '0);
      rst_n = 1'b1;
   endtask

   // Raise a request at a negedge, hold until granted, report grant latency.
   task automatic req(input logic port, input logic [W-1:0] a, input logic [W-1:0] b,
                      output int lat);
      int k;
      if (port) begin bus.REQ1 = 1'b1; bus.A1 = a; bus.B1 = b; end
      else      begin bus.REQ0 = 1'b1; bus.A0 = a; bus.B0 = b; end
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(port ? bus.GNT1 : bus.GNT0) && k < 200);
      if (k >= 200) chk("gnt_timeout", port ? bus.GNT1 : bus.GNT0, 1'b1);
      if (port) bus.REQ1 = 1'b0;
      else      bus.REQ0 = 1'b0;
      lat = k;
   endtask

   task automatic wait_idle(input int limit);
      int k;
      k = 0;
      while ((sb.size() != 0 || bus.BUSY) && k < limit) begin
         @(negedge clk);
         k++;
      end
      if (k >= limit) chk("idle_timeout", sb.size(), 0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int           lat0, lat1;
      int           busy_n;
      int           k;
      logic [W-1:0] fa[6];
      logic [W-1:0] fb[6];

      bus.REQ0 = 1'b0; bus.A0 = '0; bus.B0 = '0;
      bus.REQ1 = 1'b0; bus.A1 = '0; bus.B1 = '0;
      @(negedge clk);
      reset_for(3);

      // Single op on port 0: 0x3 * 0x5 = 0xF after 4 cycles.
      mul_lat = 4; mul_mode = 0;
      gq.push_back('{port: 1'b0, a: W'(3), b: W'(5)});
      sb.push_back('{port: 1'b0, is_err: 1'b0, val: W'('hF), chk_lat: 1'b1});
      req(1'b0, W'(3), W'(5), lat0);
      chk("gnt0_latency", lat0, 1);
      wait_idle(50);
      chk("single_result", bus.RESULT, W'('hF));

      // Tie from reset: 0 first, 1 next; a second tie goes to 0 again.
      reset_for(1);
      mul_lat = 2;
      for (int r = 0; r < 2; r++) begin
         gq.push_back('{port: 1'b0, a: W'('h1234), b: W'('h77)});
         gq.push_back('{port: 1'b1, a: W'('hABCD), b: W'('h5)});
         sb.push_back('{port: 1'b0, is_err: 1'b0, val: clmul(W'('h1234), W'('h77)), chk_lat: 1'b1});
         sb.push_back('{port: 1'b1, is_err: 1'b0, val: clmul(W'('hABCD), W'('h5)), chk_lat: 1'b1});
         fork
            req(1'b0, W'('h1234), W'('h77), lat0);
            req(1'b1, W'('hABCD), W'('h5), lat1);
         join
         chk("tie_gnt0_latency", lat0, 1);
         wait_idle(50);
      end

      // Fairness: both ports request continuously for 6 operations.
      mul_lat = 1;
      for (int i = 0; i < 6; i++) begin
         fa[i] = W'({$urandom, $urandom});
         fb[i] = W'({$urandom, $urandom});
         gq.push_back('{port: 1'(i % 2), a: fa[i], b: fb[i]});
         sb.push_back('{port: 1'(i % 2), is_err: 1'b0, val: clmul(fa[i], fb[i]), chk_lat: 1'b1});
      end
      fork
         begin
            int l;
            for (int i = 0; i < 3; i++) req(1'b0, fa[2*i], fb[2*i], l);
         end
         begin
            int l;
            for (int i = 0; i < 3; i++) req(1'b1, fa[2*i+1], fb[2*i+1], l);
         end
      join
      wait_idle(50);

      // Error and product together on port 1: ERR1 only, RESULT kept.
      mul_lat = 3; mul_mode = 1;
      gq.push_back('{port: 1'b1, a: W'('h99), b: W'('h3)});
      sb.push_back('{port: 1'b1, is_err: 1'b1, val: '0, chk_lat: 1'b1});
      req(1'b1, W'('h99), W'('h3), lat1);
      k = 0;
      while (!bus.ERR1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("err1_seen", bus.ERR1, 1'b1);
      @(negedge clk);
      chk("busy_after_err", bus.BUSY, 1'b0);
      chk("result_after_err", bus.RESULT, last_result);

      // Error without a product on port 0.
      mul_mode = 3;
      gq.push_back('{port: 1'b0, a: W'('h42), b: W'('h6)});
      sb.push_back('{port: 1'b0, is_err: 1'b1, val: '0, chk_lat: 1'b1});
      req(1'b0, W'('h42), W'('h6), lat0);
      wait_idle(50);
      mul_mode = 0;

      // Stray multiplier pulses while idle must do nothing.
      stray_req++;
      repeat (4) @(negedge clk);
      chk("stray_busy", bus.BUSY, 1'b0);
      chk("stray_result", bus.RESULT, last_result);

      // Reset during WAIT, then a late product arrives.
      mul_lat = 6;
      gq.push_back('{port: 1'b0, a: W'('h5A5), b: W'('h3C)});
      req(1'b0, W'('h5A5), W'('h3C), lat0);
      repeat (2) @(negedge clk);
      reset_for(1);
      repeat (10) @(negedge clk);
      chk("late_valid_busy", bus.BUSY, 1'b0);
      chk("late_valid_result", bus.RESULT, '0);
      mul_lat = 2;
      gq.push_back('{port: 1'b1, a: W'('h3F0), b: W'('h11)});
      sb.push_back('{port: 1'b1, is_err: 1'b0, val: clmul(W'('h3F0), W'('h11)), chk_lat: 1'b1});
      req(1'b1, W'('h3F0), W'('h11), lat1);
      chk("post_rst_gnt1_latency", lat1, 1);
      wait_idle(50);

      // Silent multiplier.
      mul_mode = 2;
      gq.push_back('{port: 1'b0, a: W'('h7), b: W'('h9)});
`ifdef ECC_MUL_ARB_TIMEOUT_EN
      sb.push_back('{port: 1'b0, is_err: 1'b1, val: '0, chk_lat: 1'b0});
      req(1'b0, W'('h7), W'('h9), lat0);
      wait_idle(TO + 20);
      chk("timeout_busy", bus.BUSY, 1'b0);
`else
      req(1'b0, W'('h7), W'('h9), lat0);
      busy_n = 0;
      repeat (1000) begin
         @(negedge clk);
         if (bus.BUSY) busy_n++;
      end
      chk("busy_hold", busy_n, 1000);
      reset_for(1);
`endif
      mul_mode = 0;

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      chk("gq_drained", gq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
